geofence_point_feeder: RTL and testbench
========================================

# geofence_point_feeder

Buffered front-end that sits directly upstream of `geofence`. It accepts (X,Y) points from a host over a valid/ready handshake and stores them in a FIFO. Once a full 7-point frame is buffered (object point, then antennas 1–6), it drives `geofence` with one point per cycle, with no gaps. It then waits for `geofence`'s `valid` pulse before issuing the next frame. When a frame is not ready in time, it holds `geofence` in reset rather than feeding it a gapped stream.

## Interface
- `FIFO_DEPTH`, 16: point entries; power of two, ≥7; ≥14 required for back-to-back frames.
- `WAIT_TIMEOUT`, 4096: max cycles in WAIT before abort.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `in_valid` in 1: host point valid.
- `in_ready` out 1: FIFO not full (combinational from registered count).
- `in_x` in 10: host point X.
- `in_y` in 10: host point Y.
- `X` out 10: point to `geofence.X`, registered.
- `Y` out 10: point to `geofence.Y`, registered.
- `gf_reset` out 1: drives `geofence.reset`, registered, async-set by `reset`.
- `gf_valid` in 1: `geofence.valid`.
- `frames_done` out 16: count of `gf_valid` pulses received, wraps at 65535→0.
- `err` out 1: sticky timeout flag, cleared only by `reset`.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: current occupancy.

## Operation
- FIFO entries are 20 bits, {x,y}.
- Push occurs when `in_valid && in_ready`. `in_ready = (fifo_count != FIFO_DEPTH)`. A push is refused when full, even if a pop happens on the same edge.
- A push and a pop on the same edge leave `fifo_count` unchanged.
- FSM states are IDLE, STREAM and WAIT. All decisions use pre-edge registered `fifo_count`.
- IDLE:
  - `gf_reset`=1.
  - If `fifo_count`≥7: pop point0 into X/Y, set `gf_reset`<=0, set idx<=1, go to STREAM.
- STREAM:
  - Pop one point into X/Y each edge and increment idx.
  - At idx==6, pop point6 and go to WAIT.
  - STREAM never underflows, because 7 entries were guaranteed on entry.
- WAIT:
  - X/Y hold point6 and the timeout counter increments.
  - On `gf_valid`=1: increment `frames_done`.
    - If `fifo_count`≥7: pop the next point0 on that same edge, set idx<=1, go to STREAM. `gf_reset` stays 0.
    - Otherwise: set `gf_reset`<=1 and go to IDLE.
  - If the counter reaches WAIT_TIMEOUT before `gf_valid`: set `err`<=1, `gf_reset`<=1, go to IDLE. The frame is abandoned and `frames_done` is unchanged.
- `gf_valid` is ignored in IDLE and STREAM.
- Reset values:
  - State IDLE, FIFO empty, X=Y=0.
  - `gf_reset`=1, `frames_done`=0, `err`=0, `fifo_count`=0.
  - `in_ready`=1.

## Timing
- `geofence` samples point0 on the first edge where it sees `gf_reset`=0. This is one edge after the feeder's release edge, because X/Y=point0 is loaded on that same release edge.
- Initial latency: the 7th point is written at edge E. IDLE detects the full frame at E+1, and X/Y=point0 at E+1. Points 0..6 then appear on X/Y during cycles E+1..E+7, one per cycle.
- Back-to-back frames: if `gf_valid` is sampled high at edge V, X/Y=next point0 from V. `geofence` samples it at V+1.
- Underrun recovery: `gf_reset` rises at V. It falls one edge after `fifo_count` reaches 7.
- Timeout: `err` is set on the edge where the WAIT counter equals WAIT_TIMEOUT (WAIT_TIMEOUT cycles after WAIT entry).
- Assertion of `reset` mid-STREAM or mid-WAIT:
  - `gf_reset`=1 and X=Y=0 immediately (asynchronous).
  - FIFO flushed, `frames_done`=0, `err`=0.
  - Operation restarts from IDLE after deassertion.

## Test plan
- Reset, then push (5,5),(1,1),(9,1),(12,6),(9,11),(1,11),(0,6) on consecutive cycles. Required:
  - `gf_reset` falls the edge after the 7th push.
  - X/Y show the seven points in order on 7 consecutive cycles.
  - X/Y hold (0,6) in WAIT.
- Push 14 points, then pulse `gf_valid` 20 cycles after point6. Required:
  - X/Y = point7 on the `gf_valid` edge.
  - `gf_reset` stays 0.
  - `frames_done`=1.
  - Second frame streams with no gap.
- Push 10 points, then pulse `gf_valid`. Required:
  - `gf_reset`=1 on the next cycle, held until 4 more points are pushed.
  - `gf_reset` falls one edge after `fifo_count`=7.
- With FIFO_DEPTH=16, after the first frame is in WAIT, hold `in_valid`=1 for 20 beats. Required:
  - `in_ready`=0 at `fifo_count`=16.
  - Beat 17 is held by the host and not lost.
  - Data order is preserved after `gf_valid`.
- With WAIT_TIMEOUT=8, never assert `gf_valid`. Required:
  - `err`=1 and `gf_reset`=1 eight cycles after WAIT entry.
  - State returns to IDLE and `frames_done`=0.
- Assert `reset` at the 4th STREAM cycle. Required:
  - `gf_reset`=1, X=Y=0 and `fifo_count`=0 immediately.
  - After release, a fresh 7-point push streams correctly.

Source files
------------

// File: rtl/geofence_point_feeder.sv
// rtl/geofence_point_feeder.sv - point FIFO that feeds geofence gap-free 7-point frames
// Holds geofence in reset whenever a full frame is not buffered.
module geofence_point_feeder #(
  parameter int FIFO_DEPTH   = 16,
  parameter int WAIT_TIMEOUT = 4096
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [9:0]                    in_x,
  input  logic [9:0]                    in_y,
  output logic [9:0]                    X,
  output logic [9:0]                    Y,
  output logic                          gf_reset,
  input  logic                          gf_valid,
  output logic [15:0]                   frames_done,
  output logic                          err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(WAIT_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_WAIT
  } state_t;

  state_t         state;
  logic [2:0]     idx;
  logic [TW-1:0]  wait_cnt;

  logic [19:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [19:0]    rd_data;
  logic           push;
  logic           pop;
  logic           frame_ready;

  assign in_ready    = (fifo_count != CW'(FIFO_DEPTH));
  assign push        = in_valid && in_ready;
  assign frame_ready = (fifo_count >= CW'(7));
  assign rd_data     = mem[rd_ptr];

  // Pop decisions only look at the pre-edge count, so a same-edge push never helps.
  always_comb begin
    pop = 1'b0;
    case (state)
      ST_IDLE:   pop = frame_ready;
      ST_STREAM: pop = 1'b1;
      ST_WAIT:   pop = gf_valid && frame_ready;
      default:   pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_x, in_y};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      X           <= '0;
      Y           <= '0;
      gf_reset    <= 1'b1;
      idx         <= '0;
      wait_cnt    <= '0;
      frames_done <= '0;
      err         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_ready) begin
            X        <= rd_data[19:10];
            Y        <= rd_data[9:0];
            gf_reset <= 1'b0;
            idx      <= 3'd1;
            state    <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          X <= rd_data[19:10];
          Y <= rd_data[9:0];
          if (idx == 3'd6) begin
            wait_cnt <= '0;
            state    <= ST_WAIT;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        ST_WAIT: begin
          if (gf_valid) begin
            frames_done <= frames_done + 16'd1;
            if (frame_ready) begin
              X     <= rd_data[19:10];
              Y     <= rd_data[9:0];
              idx   <= 3'd1;
              state <= ST_STREAM;
            end else begin
              gf_reset <= 1'b1;
              state    <= ST_IDLE;
            end
          end else if (wait_cnt == TW'(WAIT_TIMEOUT - 1)) begin
            // Abandoned frame: geofence never answered, restart it cleanly.
            err      <= 1'b1;
            gf_reset <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          gf_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_geofence_point_feeder.sv
// tb/tb_geofence_point_feeder.sv - directed bench for geofence_point_feeder
// Main instance uses a long timeout; a second instance with timeout 8 covers the abort path.
`timescale 1ns/1ps
module tb_geofence_point_feeder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [9:0]  in_x = '0;
  logic [9:0]  in_y = '0;
  logic [9:0]  X;
  logic [9:0]  Y;
  logic        gf_reset;
  logic        gf_valid = 1'b0;
  logic [15:0] frames_done;
  logic        err;
  logic [4:0]  fifo_count;

  logic        t_in_valid = 1'b0;
  logic        t_in_ready;
  logic [9:0]  t_in_x = '0;
  logic [9:0]  t_in_y = '0;
  logic [9:0]  t_x;
  logic [9:0]  t_y;
  logic        t_gf_reset;
  logic        t_gf_valid = 1'b0;
  logic [15:0] t_frames_done;
  logic        t_err;
  logic [4:0]  t_fifo_count;

  int checks = 0;
  int failures = 0;
  logic [9:0] px [32];
  logic [9:0] py [32];

  always #5 clk = ~clk;

  geofence_point_feeder #(.FIFO_DEPTH(16), .WAIT_TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .X(X), .Y(Y), .gf_reset(gf_reset),
    .gf_valid(gf_valid), .frames_done(frames_done), .err(err), .fifo_count(fifo_count)
  );

  geofence_point_feeder #(.FIFO_DEPTH(16), .WAIT_TIMEOUT(8)) dut_t (
    .clk(clk), .reset(reset), .in_valid(t_in_valid), .in_ready(t_in_ready),
    .in_x(t_in_x), .in_y(t_in_y), .X(t_x), .Y(t_y), .gf_reset(t_gf_reset),
    .gf_valid(t_gf_valid), .frames_done(t_frames_done), .err(t_err), .fifo_count(t_fifo_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    in_valid   = 1'b0;
    gf_valid   = 1'b0;
    t_in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic push_run(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_x     = px[first + i];
      in_y     = py[first + i];
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic check_xy(input string tag, input int i);
    check({tag, "_x"}, 32'(X), 32'(px[i]));
    check({tag, "_y"}, 32'(Y), 32'(py[i]));
  endtask

  task automatic load_frame1();
    px[0] = 10'd5;  py[0] = 10'd5;
    px[1] = 10'd1;  py[1] = 10'd1;
    px[2] = 10'd9;  py[2] = 10'd1;
    px[3] = 10'd12; py[3] = 10'd6;
    px[4] = 10'd9;  py[4] = 10'd11;
    px[5] = 10'd1;  py[5] = 10'd11;
    px[6] = 10'd0;  py[6] = 10'd6;
  endtask

  initial begin
    // Reset values and first frame latency
    load_frame1();
    do_reset();
    check("rst_gf_reset", 32'(gf_reset), 1);
    check("rst_x", 32'(X), 0);
    check("rst_y", 32'(Y), 0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_ready", 32'(in_ready), 1);
    check("rst_frames", 32'(frames_done), 0);
    check("rst_err", 32'(err), 0);
    push_run(0, 7);
    check("t1_gf_reset_at_e", 32'(gf_reset), 1);
    check("t1_count", 32'(fifo_count), 7);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("t1_gf_reset_low", 32'(gf_reset), 0);
      check_xy("t1_pt", i);
    end
    repeat (3) tick();
    check_xy("t1_hold", 6);
    check("t1_count_wait", 32'(fifo_count), 0);

    // Back-to-back frames
    for (int i = 0; i < 14; i++) begin
      px[i] = 10'(i * 7 + 3);
      py[i] = 10'(i * 5 + 100);
    end
    do_reset();
    push_run(0, 14);
    check_xy("t2_p6", 6);
    check("t2_count", 32'(fifo_count), 7);
    repeat (19) tick();
    check_xy("t2_hold", 6);
    gf_valid = 1'b1;
    tick();
    gf_valid = 1'b0;
    check_xy("t2_p7", 7);
    check("t2_gf_reset", 32'(gf_reset), 0);
    check("t2_frames", 32'(frames_done), 1);
    for (int i = 8; i < 14; i++) begin
      tick();
      check_xy("t2_pt", i);
      check("t2_nogap", 32'(gf_reset), 0);
    end

    // Underrun recovery
    for (int i = 0; i < 14; i++) begin
      px[i] = 10'(i + 200);
      py[i] = 10'(300 - i);
    end
    do_reset();
    push_run(0, 10);
    check("t3_count10", 32'(fifo_count), 7);
    repeat (4) tick();
    check_xy("t3_p6", 6);
    check("t3_count_left", 32'(fifo_count), 3);
    gf_valid = 1'b1;
    tick();
    gf_valid = 1'b0;
    check("t3_gf_reset_up", 32'(gf_reset), 1);
    check("t3_frames", 32'(frames_done), 1);
    for (int i = 10; i < 14; i++) begin
      in_valid = 1'b1;
      in_x     = px[i];
      in_y     = py[i];
      tick();
      check("t3_held", 32'(gf_reset), 1);
    end
    in_valid = 1'b0;
    check("t3_count7", 32'(fifo_count), 7);
    tick();
    check("t3_release", 32'(gf_reset), 0);
    check_xy("t3_p7", 7);

    // FIFO full backpressure
    begin
      int exp_cnt;
      int k;
      logic exp_rdy;
      for (int i = 0; i < 32; i++) begin
        px[i] = 10'(i * 11 + 1);
        py[i] = 10'(i * 13 + 2);
      end
      do_reset();
      push_run(0, 7);
      repeat (7) tick();
      check("t4_wait_empty", 32'(fifo_count), 0);
      exp_cnt = 0;
      k = 0;
      for (int b = 0; b < 20; b++) begin
        in_valid = 1'b1;
        in_x     = px[7 + k];
        in_y     = py[7 + k];
        exp_rdy  = (exp_cnt != 16);
        check("t4_ready", 32'(in_ready), 32'(exp_rdy));
        tick();
        if (exp_rdy) begin
          exp_cnt++;
          k++;
        end
      end
      check("t4_full", 32'(fifo_count), 16);
      check("t4_not_ready", 32'(in_ready), 0);
      gf_valid = 1'b1;
      tick();
      gf_valid = 1'b0;
      check_xy("t4_p7", 7);
      check("t4_refused", 32'(fifo_count), 15);
      tick();
      in_valid = 1'b0;
      check_xy("t4_p8", 8);
      check("t4_beat17_in", 32'(fifo_count), 15);
      for (int i = 9; i < 14; i++) begin
        tick();
        check_xy("t4_f2", i);
      end
      gf_valid = 1'b1;
      tick();
      gf_valid = 1'b0;
      check_xy("t4_p14", 14);
      for (int i = 15; i < 21; i++) begin
        tick();
        check_xy("t4_f3", i);
      end
      check("t4_left", 32'(fifo_count), 3);
      gf_valid = 1'b1;
      tick();
      gf_valid = 1'b0;
      check("t4_underrun", 32'(gf_reset), 1);
      check("t4_frames", 32'(frames_done), 3);
      push_run(24, 4);
      for (int i = 21; i < 25; i++) begin
        tick();
        check_xy("t4_tail", i);
      end
    end

    // Timeout on the short-timeout instance
    load_frame1();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      t_in_valid = 1'b1;
      t_in_x     = px[i];
      t_in_y     = py[i];
      tick();
    end
    t_in_valid = 1'b0;
    repeat (7) tick();
    check("t5_in_wait_x", 32'(t_x), 32'(px[6]));
    check("t5_gf_reset_wait", 32'(t_gf_reset), 0);
    repeat (7) tick();
    check("t5_err_early", 32'(t_err), 0);
    check("t5_gf_reset_early", 32'(t_gf_reset), 0);
    tick();
    check("t5_err", 32'(t_err), 1);
    check("t5_gf_reset", 32'(t_gf_reset), 1);
    check("t5_frames", 32'(t_frames_done), 0);
    tick();
    check("t5_idle", 32'(t_gf_reset), 1);
    check("t5_err_sticky", 32'(t_err), 1);

    // Asynchronous reset mid-STREAM
    do_reset();
    push_run(0, 7);
    repeat (4) tick();
    check_xy("t6_p3", 3);
    reset = 1'b1;
    #1;
    check("t6_gf_reset", 32'(gf_reset), 1);
    check("t6_x", 32'(X), 0);
    check("t6_y", 32'(Y), 0);
    check("t6_count", 32'(fifo_count), 0);
    check("t6_ready", 32'(in_ready), 1);
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      px[i] = 10'(i * 3 + 500);
      py[i] = 10'(i * 2 + 40);
    end
    push_run(0, 7);
    for (int i = 0; i < 7; i++) begin
      tick();
      check_xy("t6_fresh", i);
    end
    check("t6_err", 32'(err), 0);
    check("t6_frames", 32'(frames_done), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
